// File: rtl/telemetry_uart_scheduler.sv
// Round-robin arbiter that frames one word from one of three telemetry FIFOs
// into SYNC, ID, payload (MSB first), XOR checksum bytes for a shared uart_tx.
module telemetry_uart_scheduler #(
    parameter int         TACH_WIDTH = 96,
    parameter int         IR_WIDTH   = 64,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  ltach_empty,
    input  logic [TACH_WIDTH-1:0] ltach_dout,
    output logic                  ltach_rd_en,
    input  logic                  rtach_empty,
    input  logic [TACH_WIDTH-1:0] rtach_dout,
    output logic                  rtach_rd_en,
    input  logic                  ir_empty,
    input  logic [IR_WIDTH-1:0]   ir_dout,
    output logic                  ir_rd_en,
    output logic                  uart_start_tx,
    output logic [7:0]            uart_tx_din,
    input  logic                  uart_tx_done,
    output logic                  busy,
    output logic [1:0]            grant_id,
    output logic [15:0]           frame_count
);

    localparam int PW = (TACH_WIDTH > IR_WIDTH) ? TACH_WIDTH : IR_WIDTH;
    localparam int IW = $clog2(PW / 8 + 3);
    localparam logic [IW-1:0] ONE       = IW'(1);
    localparam logic [IW-1:0] TACH_LAST = IW'(TACH_WIDTH / 8 + 1);
    localparam logic [IW-1:0] IR_LAST   = IW'(IR_WIDTH / 8 + 1);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    state_t        state_q;
    logic [1:0]    rr_q;
    logic [1:0]    grant_q;
    logic [PW-1:0] pay_q;
    logic [IW-1:0] idx_q;
    logic [7:0]    csum_q;
    logic [7:0]    din_q;
    logic [15:0]   cnt_q;
    logic          l_rd_q, r_rd_q, i_rd_q, start_q;

    logic [2:0]    req;
    logic [2:0]    slot;
    logic [1:0]    pick_d;
    logic          found_d;
    logic [IW-1:0] last;
    logic [7:0]    head;
    logic [PW-1:0] l_al, r_al, i_al;

    assign req  = {~ir_empty, ~rtach_empty, ~ltach_empty};
    assign head = pay_q[PW-1 -: 8];
    assign last = (grant_q == 2'd3) ? IR_LAST : TACH_LAST;

    // Narrower words are left-aligned so the payload always leaves from the top.
    assign l_al = PW'(ltach_dout) << (PW - TACH_WIDTH);
    assign r_al = PW'(rtach_dout) << (PW - TACH_WIDTH);
    assign i_al = PW'(ir_dout) << (PW - IR_WIDTH);

    always_comb begin
        found_d = 1'b0;
        pick_d  = 2'd0;
        slot    = 3'd0;
        for (int k = 0; k < 3; k++) begin
            slot = {1'b0, rr_q} + 3'(k);
            if (slot >= 3'd3) slot = slot - 3'd3;
            if (!found_d && req[slot[1:0]]) begin
                found_d = 1'b1;
                pick_d  = slot[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 2'd0;
            grant_q <= 2'd0;
            pay_q   <= '0;
            idx_q   <= '0;
            csum_q  <= 8'd0;
            din_q   <= 8'd0;
            cnt_q   <= 16'd0;
            l_rd_q  <= 1'b0;
            r_rd_q  <= 1'b0;
            i_rd_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            l_rd_q  <= 1'b0;
            r_rd_q  <= 1'b0;
            i_rd_q  <= 1'b0;
            start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (en && found_d) begin
                        state_q <= LOAD;
                        grant_q <= pick_d + 2'd1;
                        rr_q    <= (pick_d == 2'd2) ? 2'd0 : pick_d + 2'd1;
                        l_rd_q  <= (pick_d == 2'd0);
                        r_rd_q  <= (pick_d == 2'd1);
                        i_rd_q  <= (pick_d == 2'd2);
                    end
                end
                LOAD: begin
                    unique case (grant_q)
                        2'd1:    pay_q <= l_al;
                        2'd2:    pay_q <= r_al;
                        default: pay_q <= i_al;
                    endcase
                    idx_q   <= '0;
                    csum_q  <= {6'd0, grant_q};
                    din_q   <= SYNC_BYTE;
                    start_q <= 1'b1;
                    state_q <= START;
                end
                START: state_q <= WAIT;
                WAIT: begin
                    if (uart_tx_done) begin
                        if (idx_q == last + ONE) begin
                            cnt_q   <= cnt_q + 16'd1;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + ONE;
                            start_q <= 1'b1;
                            state_q <= START;
                            if (idx_q == '0) begin
                                din_q <= {6'd0, grant_q};
                            end else if (idx_q == last) begin
                                din_q <= csum_q;
                            end else begin
                                din_q  <= head;
                                csum_q <= csum_q ^ head;
                                pay_q  <= pay_q << 8;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ltach_rd_en   = l_rd_q;
    assign rtach_rd_en   = r_rd_q;
    assign ir_rd_en      = i_rd_q;
    assign uart_start_tx = start_q;
    assign uart_tx_din   = din_q;
    assign busy          = (state_q != IDLE);
    assign grant_id      = grant_q;
    assign frame_count   = cnt_q;

endmodule
